// File: rtl/lock_pkg.sv
`default_nettype none
// ============================================================================
// lock_pkg: constants, code type and editor state type for the lock's password
// editor. Revision: 1.0
// ============================================================================
package lock_pkg;

  localparam logic [2:0] LOCK_UNLOCKED = 3'd4;
  localparam int         NUM_DIGITS    = 8;
  localparam logic [3:0] DIGIT_MAX     = 4'd9;

  // Element 0 is digit1, so a BCD word like 32'h1234_5678 maps straight across.
  typedef logic [0:NUM_DIGITS-1][3:0] code_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ENTRY   = 2'd1,
    ST_CONFIRM = 2'd2,
    ST_CHECK   = 2'd3
  } edit_state_e;

  function automatic logic [3:0] digit_inc(input logic [3:0] d);
    return (d >= DIGIT_MAX) ? 4'd0 : d + 4'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_sync_edge.sv
`default_nettype none
// ============================================================================
// btn_sync_edge: two-flop synchronizer plus rising-edge detector, one-cycle
// pulse per press. Revision: 1.0
// ============================================================================
module btn_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic pulse_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign pulse_o = sync2_q & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/password_writer.sv
`default_nettype none
// ============================================================================
// password_writer: edits and commits the 8-digit lock password while unlocked.
// PW_CONFIRM_EN enables the second (confirmation) entry pass. Revision: 1.0
// ============================================================================
module password_writer
  import lock_pkg::*;
#(
  parameter logic [31:0] DEFAULT_PASSWORD = 32'h1234_5678,
  parameter int unsigned TIMEOUT_CYCLES   = 500_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] lock_state,
  input  logic       btn_set,
  input  logic       btn_inc,
  input  logic       btn_next,
  output logic [3:0] digit1_password,
  output logic [3:0] digit2_password,
  output logic [3:0] digit3_password,
  output logic [3:0] digit4_password,
  output logic [3:0] digit5_password,
  output logic [3:0] digit6_password,
  output logic [3:0] digit7_password,
  output logic [3:0] digit8_password,
  output logic       edit_active,
  output logic       edit_phase,
  output logic [2:0] edit_index,
  output logic [3:0] edit_value,
  output logic       commit_ok,
  output logic       commit_fail,
  output logic       edit_abort
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]       IDX_LAST = 3'(NUM_DIGITS - 1);

  logic set_pulse;
  logic inc_pulse;
  logic next_pulse;

  edit_state_e      state_q, state_d;
  logic [2:0]       index_q, index_d;
  logic [3:0]       value_q, value_d;
  code_t            entry_q, entry_d;
  code_t            pw_q, pw_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             active_q, active_d;
  logic             ok_q, ok_d;
  logic             abort_q, abort_d;
`ifdef PW_CONFIRM_EN
  code_t            confirm_q, confirm_d;
  logic             phase_q, phase_d;
  logic             fail_q, fail_d;
`endif

  btn_sync_edge u_sync_set  (.clk(clk), .rst(rst), .btn_i(btn_set),  .pulse_o(set_pulse));
  btn_sync_edge u_sync_inc  (.clk(clk), .rst(rst), .btn_i(btn_inc),  .pulse_o(inc_pulse));
  btn_sync_edge u_sync_next (.clk(clk), .rst(rst), .btn_i(btn_next), .pulse_o(next_pulse));

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    value_d = value_q;
    entry_d = entry_q;
    pw_d    = pw_q;
    cnt_d   = '0;
    ok_d    = 1'b0;
    abort_d = 1'b0;
`ifdef PW_CONFIRM_EN
    confirm_d = confirm_q;
    fail_d    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (set_pulse && lock_state == LOCK_UNLOCKED) begin
          state_d = ST_ENTRY;
          index_d = '0;
          value_d = '0;
          entry_d = '0;
`ifdef PW_CONFIRM_EN
          confirm_d = '0;
`endif
        end
      end
      ST_ENTRY, ST_CONFIRM: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Cancel, lock loss and timeout all abandon the edit the same way.
        if (set_pulse || lock_state != LOCK_UNLOCKED || cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          index_d = '0;
          value_d = '0;
          cnt_d   = '0;
          abort_d = 1'b1;
        end else if (next_pulse) begin
          cnt_d = '0;
`ifdef PW_CONFIRM_EN
          if (state_q == ST_CONFIRM) confirm_d[index_q] = value_q;
          else                       entry_d[index_q]   = value_q;
`else
          entry_d[index_q] = value_q;
`endif
          index_d = index_q + 3'd1;
          value_d = '0;
          if (index_q == IDX_LAST) begin
            index_d = '0;
`ifdef PW_CONFIRM_EN
            state_d = (state_q == ST_ENTRY) ? ST_CONFIRM : ST_CHECK;
`else
            state_d = ST_CHECK;
`endif
          end
        end else if (inc_pulse) begin
          cnt_d   = '0;
          value_d = digit_inc(value_q);
        end
      end
      ST_CHECK: begin
        state_d = ST_IDLE;
`ifdef PW_CONFIRM_EN
        if (entry_q == confirm_q) begin
          pw_d = entry_q;
          ok_d = 1'b1;
        end else begin
          fail_d = 1'b1;
        end
`else
        pw_d = entry_q;
        ok_d = 1'b1;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
    active_d = (state_d != ST_IDLE);
`ifdef PW_CONFIRM_EN
    phase_d = (state_d == ST_CONFIRM);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      index_q  <= '0;
      value_q  <= '0;
      entry_q  <= '0;
      pw_q     <= DEFAULT_PASSWORD;
      cnt_q    <= '0;
      active_q <= 1'b0;
      ok_q     <= 1'b0;
      abort_q  <= 1'b0;
`ifdef PW_CONFIRM_EN
      confirm_q <= '0;
      phase_q   <= 1'b0;
      fail_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      index_q  <= index_d;
      value_q  <= value_d;
      entry_q  <= entry_d;
      pw_q     <= pw_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      ok_q     <= ok_d;
      abort_q  <= abort_d;
`ifdef PW_CONFIRM_EN
      confirm_q <= confirm_d;
      phase_q   <= phase_d;
      fail_q    <= fail_d;
`endif
    end
  end

  assign digit1_password = pw_q[0];
  assign digit2_password = pw_q[1];
  assign digit3_password = pw_q[2];
  assign digit4_password = pw_q[3];
  assign digit5_password = pw_q[4];
  assign digit6_password = pw_q[5];
  assign digit7_password = pw_q[6];
  assign digit8_password = pw_q[7];
  assign edit_active     = active_q;
  assign edit_index      = index_q;
  assign edit_value      = value_q;
  assign commit_ok       = ok_q;
  assign edit_abort      = abort_q;
`ifdef PW_CONFIRM_EN
  assign edit_phase      = phase_q;
  assign commit_fail     = fail_q;
`else
  assign edit_phase      = 1'b0;
  assign commit_fail     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_password_writer.sv
`default_nettype none
// tb_password_writer: directed and randomized button sequences checked against a
// behavioural model of the password editor.
module tb_password_writer;

  localparam logic [31:0] DEF_PW = 32'h1234_5678;
  localparam logic [31:0] CODE_A = 32'h9000_0001;
  localparam logic [31:0] CODE_B = 32'h9000_0002;
`ifdef PW_CONFIRM_EN
  localparam bit CONF = 1'b1;
`else
  localparam bit CONF = 1'b0;
`endif

  logic       clk, rst;
  logic [2:0] lock_state;
  logic       btn_set, btn_inc, btn_next;
  logic [3:0] d1, d2, d3, d4, d5, d6, d7, d8;
  logic       edit_active, edit_phase;
  logic [2:0] edit_index;
  logic [3:0] edit_value;
  logic       commit_ok, commit_fail, edit_abort;
  logic [31:0] dut_pw;

  int n_checks, n_errors;
  int got_ok, got_fail, got_abort;
  int exp_ok, exp_fail, exp_abort;
  int m_pw[8], m_ebuf[8], m_cbuf[8];
  bit m_edit;
  int m_phase, m_idx, m_val;

  password_writer #(.DEFAULT_PASSWORD(DEF_PW), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst(rst), .lock_state(lock_state),
    .btn_set(btn_set), .btn_inc(btn_inc), .btn_next(btn_next),
    .digit1_password(d1), .digit2_password(d2), .digit3_password(d3), .digit4_password(d4),
    .digit5_password(d5), .digit6_password(d6), .digit7_password(d7), .digit8_password(d8),
    .edit_active(edit_active), .edit_phase(edit_phase), .edit_index(edit_index),
    .edit_value(edit_value), .commit_ok(commit_ok), .commit_fail(commit_fail),
    .edit_abort(edit_abort)
  );

  assign dut_pw = {d1, d2, d3, d4, d5, d6, d7, d8};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycles each status pulse is seen high; a correct pulse adds exactly one.
  always @(negedge clk) begin
    if (commit_ok)   got_ok++;
    if (commit_fail) got_fail++;
    if (edit_abort)  got_abort++;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  function automatic void mdl_reset();
    m_pw   = '{1, 2, 3, 4, 5, 6, 7, 8};
    m_edit = 1'b0;
  endfunction

  function automatic logic [31:0] m_pw_packed();
    logic [31:0] v = '0;
    for (int i = 0; i < 8; i++) v = {v[27:0], 4'(m_pw[i])};
    return v;
  endfunction

  function automatic bit bufs_equal();
    for (int i = 0; i < 8; i++) if (m_ebuf[i] != m_cbuf[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void mdl_press(input bit s, input bit i, input bit n);
    if (!m_edit) begin
      if (s && lock_state == 3'd4) begin
        m_edit = 1'b1; m_phase = 0; m_idx = 0; m_val = 0;
        for (int k = 0; k < 8; k++) begin m_ebuf[k] = 0; m_cbuf[k] = 0; end
      end
    end else if (s) begin
      m_edit = 1'b0; exp_abort++;
    end else if (n) begin
      if (m_phase == 0) m_ebuf[m_idx] = m_val; else m_cbuf[m_idx] = m_val;
      m_val = 0;
      if (m_idx == 7) begin
        m_idx = 0;
        if (CONF && m_phase == 0) m_phase = 1;
        else begin
          m_edit = 1'b0;
          if (!CONF || bufs_equal()) begin m_pw = m_ebuf; exp_ok++; end
          else exp_fail++;
        end
      end else m_idx++;
    end else if (i) begin
      m_val = (m_val + 1) % 10;
    end
  endfunction

  task automatic press(input bit s, input bit i, input bit n);
    @(negedge clk);
    btn_set = s; btn_inc = i; btn_next = n;
    repeat (2) @(negedge clk);
    btn_set = 1'b0; btn_inc = 1'b0; btn_next = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    mdl_press(s, i, n);
  endtask

  task automatic set_lock(input logic [2:0] v);
    @(negedge clk);
    lock_state = v;
    repeat (2) @(negedge clk);
    #1;
    if (m_edit && v != 3'd4) begin m_edit = 1'b0; exp_abort++; end
  endtask

  task automatic enter_digits(input logic [31:0] code, input bit last_next);
    logic [3:0] d;
    for (int k = 0; k < 8; k++) begin
      d = code[31-4*k -: 4];
      repeat (int'(d)) press(1'b0, 1'b1, 1'b0);
      if (k < 7 || last_next) press(1'b0, 1'b0, 1'b1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; lock_state = 3'd4;
    btn_set = 1'b0; btn_inc = 1'b0; btn_next = 1'b0;
    mdl_reset();
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (dut_pw !== DEF_PW) begin n_errors++; $display("FAIL reset_pw: got %h expected %h", dut_pw, DEF_PW); end
    n_checks++;
    if ({edit_active, edit_phase, edit_index, edit_value} !== 9'd0) begin
      n_errors++; $display("FAIL reset_edit: got %b%b %0d %0d expected 0 0 0 0", edit_active, edit_phase, edit_index, edit_value);
    end
    n_checks++;
    if ({commit_ok, commit_fail, edit_abort} !== 3'b000) begin
      n_errors++; $display("FAIL reset_status: got %b expected 000", {commit_ok, commit_fail, edit_abort});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_commit_ok();
    press(1'b1, 1'b0, 1'b0);
    if (CONF) enter_digits(CODE_A, 1'b1);
    enter_digits(CODE_A, 1'b0);
    @(negedge clk);
    btn_next = 1'b1;
    repeat (2) @(negedge clk);
    btn_next = 1'b0;
    @(negedge clk); #1;
    n_checks++;
    if (edit_active !== 1'b1 || commit_ok !== 1'b0) begin
      n_errors++; $display("FAIL commit_check_cycle: got active=%b ok=%b expected 1 0", edit_active, commit_ok);
    end
    @(negedge clk); #1;
    n_checks++;
    if (commit_ok !== 1'b1 || edit_active !== 1'b0 || dut_pw !== CODE_A) begin
      n_errors++; $display("FAIL commit_edge: got ok=%b active=%b pw=%h expected 1 0 %h", commit_ok, edit_active, dut_pw, CODE_A);
    end
    @(negedge clk); #1;
    n_checks++;
    if (commit_ok !== 1'b0) begin n_errors++; $display("FAIL commit_pulse_width: got %b expected 0", commit_ok); end
    mdl_press(1'b0, 1'b0, 1'b1);
    n_checks++;
    if (got_ok != exp_ok || dut_pw !== m_pw_packed()) begin
      n_errors++; $display("FAIL commit_model: got ok=%0d pw=%h expected %0d %h", got_ok, dut_pw, exp_ok, m_pw_packed());
    end
  endtask

  task automatic test_commit_fail();
    press(1'b1, 1'b0, 1'b0);
    if (CONF) enter_digits(CODE_A, 1'b1);
    enter_digits(CODE_B, 1'b1);
    n_checks++;
    if (dut_pw !== m_pw_packed() || edit_active !== 1'b0) begin
      n_errors++; $display("FAIL mismatch_pw: got %h active=%b expected %h 0", dut_pw, edit_active, m_pw_packed());
    end
    n_checks++;
    if (got_ok != exp_ok || got_fail != exp_fail) begin
      n_errors++; $display("FAIL mismatch_status: got ok=%0d fail=%0d expected %0d %0d", got_ok, got_fail, exp_ok, exp_fail);
    end
  endtask

  task automatic test_lock_guard();
    set_lock(3'd2);
    press(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (edit_active !== 1'b0) begin n_errors++; $display("FAIL locked_set: got active=%b expected 0", edit_active); end
    set_lock(3'd4);
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    n_checks++;
    if (edit_active !== 1'b1 || edit_value !== 4'd1) begin
      n_errors++; $display("FAIL unlocked_set: got active=%b value=%0d expected 1 1", edit_active, edit_value);
    end
    @(negedge clk);
    lock_state = 3'd0;
    @(negedge clk); #1;
    n_checks++;
    if (edit_active !== 1'b0 || edit_abort !== 1'b1) begin
      n_errors++; $display("FAIL lock_leave_abort: got active=%b abort=%b expected 0 1", edit_active, edit_abort);
    end
    m_edit = 1'b0; exp_abort++;
    set_lock(3'd4);
    n_checks++;
    if (got_abort != exp_abort) begin n_errors++; $display("FAIL lock_leave_count: got %0d expected %0d", got_abort, exp_abort); end
  endtask

  task automatic test_inc_wrap();
    press(1'b1, 1'b0, 1'b0);
    repeat (10) press(1'b0, 1'b1, 1'b0);
    n_checks++;
    if (edit_value !== 4'(m_val) || edit_value !== 4'd0) begin
      n_errors++; $display("FAIL inc_wrap: got %0d expected 0", edit_value);
    end
    press(1'b0, 1'b1, 1'b1);
    n_checks++;
    if (edit_index !== 3'd1 || edit_value !== 4'd0) begin
      n_errors++; $display("FAIL inc_next_prio: got idx=%0d val=%0d expected 1 0", edit_index, edit_value);
    end
    press(1'b1, 1'b0, 1'b1);
    n_checks++;
    if (edit_active !== 1'b0 || got_abort != exp_abort) begin
      n_errors++; $display("FAIL set_next_prio: got active=%b aborts=%0d expected 0 %0d", edit_active, got_abort, exp_abort);
    end
  endtask

  task automatic test_latency();
    press(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    btn_inc = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (edit_value !== 4'd0) begin n_errors++; $display("FAIL latency_early: got %0d expected 0", edit_value); end
    btn_inc = 1'b0;
    @(negedge clk); #1;
    n_checks++;
    if (edit_value !== 4'd1) begin n_errors++; $display("FAIL latency_3clk: got %0d expected 1", edit_value); end
    repeat (2) @(negedge clk);
    #1;
    mdl_press(1'b0, 1'b1, 1'b0);
    press(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    @(negedge clk);
    btn_set = 1'b1;
    for (int k = 1; k <= 106; k++) begin
      @(negedge clk); #1;
      if (k == 2) btn_set = 1'b0;
      if (k == 102) begin
        n_checks++;
        if (edit_active !== 1'b1 || edit_abort !== 1'b0) begin
          n_errors++; $display("FAIL timeout_early: got active=%b abort=%b expected 1 0", edit_active, edit_abort);
        end
      end
      if (k == 103) begin
        n_checks++;
        if (edit_active !== 1'b0 || edit_abort !== 1'b1) begin
          n_errors++; $display("FAIL timeout_abort: got active=%b abort=%b expected 0 1", edit_active, edit_abort);
        end
      end
    end
    exp_abort++;
  endtask

  task automatic test_random_steps();
    int r;
    logic [2:0] v;
    for (int s = 0; s < 250; s++) begin
      r = $urandom_range(0, 99);
      if (r < 50)      press(1'b0, 1'b1, 1'b0);
      else if (r < 78) press(1'b0, 1'b0, 1'b1);
      else if (r < 84) press(1'b0, 1'b1, 1'b1);
      else if (r < 87) press(1'b1, 1'b0, 1'b1);
      else if (r < 90) press(1'b1, 1'b1, 1'b1);
      else if (r < 96) press(1'b1, 1'b0, 1'b0);
      else begin
        v = 3'($urandom_range(0, 6));
        if (v >= 3'd4) v = v + 3'd1;
        set_lock(v);
        set_lock(3'd4);
      end
      n_checks++;
      if (edit_active !== m_edit) begin
        n_errors++; $display("FAIL rand_active step %0d: got %b expected %b", s, edit_active, m_edit);
      end
      if (m_edit) begin
        n_checks++;
        if ({edit_phase, edit_index, edit_value} !== {1'(m_phase), 3'(m_idx), 4'(m_val)}) begin
          n_errors++; $display("FAIL rand_edit step %0d: got ph=%b idx=%0d val=%0d expected %0d %0d %0d",
                               s, edit_phase, edit_index, edit_value, m_phase, m_idx, m_val);
        end
      end
      n_checks++;
      if (dut_pw !== m_pw_packed()) begin
        n_errors++; $display("FAIL rand_pw step %0d: got %h expected %h", s, dut_pw, m_pw_packed());
      end
      n_checks++;
      if (got_ok != exp_ok || got_fail != exp_fail || got_abort != exp_abort) begin
        n_errors++; $display("FAIL rand_status step %0d: got %0d/%0d/%0d expected %0d/%0d/%0d",
                             s, got_ok, got_fail, got_abort, exp_ok, exp_fail, exp_abort);
      end
    end
  endtask

  task automatic test_random_codes();
    logic [31:0] c1, c2;
    int k;
    for (int r = 0; r < 4; r++) begin
      c1 = '0;
      for (int j = 0; j < 8; j++) c1 = {c1[27:0], 4'($urandom_range(0, 9))};
      c2 = c1;
      if ($urandom_range(0, 1) == 1) begin
        k = $urandom_range(0, 7);
        c2[31-4*k -: 4] = (c2[31-4*k -: 4] == 4'd9) ? 4'd0 : c2[31-4*k -: 4] + 4'd1;
      end
      if (m_edit) press(1'b1, 1'b0, 1'b0);
      press(1'b1, 1'b0, 1'b0);
      enter_digits(c1, 1'b1);
      if (CONF) enter_digits(c2, 1'b1);
      n_checks++;
      if (edit_active !== 1'b0 || dut_pw !== m_pw_packed()) begin
        n_errors++; $display("FAIL code_round %0d: got active=%b pw=%h expected 0 %h", r, edit_active, dut_pw, m_pw_packed());
      end
      n_checks++;
      if (got_ok != exp_ok || got_fail != exp_fail) begin
        n_errors++; $display("FAIL code_status %0d: got ok=%0d fail=%0d expected %0d %0d", r, got_ok, got_fail, exp_ok, exp_fail);
      end
    end
  endtask

  task automatic test_reset_mid_edit();
    if (m_edit) press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    if (CONF) enter_digits(32'h5555_5555, 1'b1);
    press(1'b0, 1'b1, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    n_checks++;
    if (edit_active !== 1'b1 || edit_phase !== 1'(m_phase)) begin
      n_errors++; $display("FAIL pre_reset_edit: got active=%b phase=%b expected 1 %0d", edit_active, edit_phase, m_phase);
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (dut_pw !== DEF_PW || edit_active !== 1'b0) begin
      n_errors++; $display("FAIL mid_reset: got pw=%h active=%b expected %h 0", dut_pw, edit_active, DEF_PW);
    end
    n_checks++;
    if ({edit_phase, edit_index, edit_value} !== 8'd0) begin
      n_errors++; $display("FAIL mid_reset_edit: got %b %0d %0d expected 0 0 0", edit_phase, edit_index, edit_value);
    end
    mdl_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    got_ok = 0; got_fail = 0; got_abort = 0;
    exp_ok = 0; exp_fail = 0; exp_abort = 0;
    m_phase = 0; m_idx = 0; m_val = 0;
    test_reset();
    test_commit_ok();
    test_commit_fail();
    test_lock_guard();
    test_inc_wrap();
    test_latency();
    test_timeout();
    test_random_steps();
    test_random_codes();
    test_reset_mid_edit();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
